tri_pipe_scheduler: RTL and testbench
=====================================

Name: tri_pipe_scheduler

Overview:
- Sequences a frame of triangles through a parametrised chain of STAGES compute stages (fetch, vertex and pixel at default) and generates per-triangle memory addresses.
- Replaces the single-state "all stages done" logic in the GPU top level. It tracks stage occupancy, so stages that hold no triangle during fill and drain do not block advance.
- Adds an abort input, correct handling of zero-triangle frames, and a sticky interrupt.

Parameters:
- MADDR_WIDTH, 32: width of the address and base-address buses.
- COUNT_WIDTH, 32: width of the triangle count and counters.
- STAGES, 3: number of pipeline stages; must be at least 1.
- VERTEX_STRIDE, 18: byte increment of addr_vertex per triangle.
- COLOR_STRIDE, 2: byte increment of addr_color per triangle.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse; sampled only in IDLE.
- abort  in  1  synchronous abort of the current frame.
- triangles_count  in  COUNT_WIDTH  triangles in the frame; latched on an accepted frame_start.
- base_addr_vertex  in  MADDR_WIDTH  vertex buffer base; latched on an accepted frame_start.
- base_addr_color  in  MADDR_WIDTH  color buffer base; latched on an accepted frame_start.
- stage_done  in  STAGES  per-stage end-of-computation pulse.
- stage_start  out  STAGES  per-stage start pulse, registered.
- stage_valid  out  STAGES  stage i currently holds a triangle.
- advance  out  1  combinational pulse; the top level loads its inter-stage data registers on it.
- addr_vertex  out  MADDR_WIDTH  vertex address of the triangle most recently issued to stage 0.
- addr_color  out  MADDR_WIDTH  color address of the triangle most recently issued to stage 0.
- issued  out  COUNT_WIDTH  number of triangles issued to stage 0.
- retired  out  COUNT_WIDTH  number of triangles that have left the last stage.
- busy  out  1  high while state is RUN.
- frame_end  out  1  one-cycle pulse at normal frame completion.
- irq  out  1  sticky frame-done interrupt.
- irq_clear  in  1  clears irq.

Behaviour:
- Reset values: every output is 0, state is IDLE, all valid and done_seen bits are 0.
- States: IDLE and RUN.
- Accepted frame_start: frame_start while in IDLE with abort=0.
  - Latches triangles_count and both bases; clears issued and retired.
  - Sets addr_vertex = base_addr_vertex and addr_color = base_addr_color.
  - If the count is 0: no transition to RUN; frame_end pulses and irq sets on the next cycle.
  - Otherwise the next state is RUN.
- frame_start while in RUN is ignored.
- done_seen[i]: set by stage_done[i] while valid[i]=1, cleared on advance. stage_done[i] while valid[i]=0 is ignored.
- ready_i = !valid[i] | done_seen[i] | stage_done[i]. A stage_done arriving in the same cycle counts.
- advance = RUN & !abort & all ready_i. The first RUN cycle always advances, because the pipeline is empty.
- On advance, at the next edge:
  - issue = (issued < latched count).
  - valid[0] <= issue; valid[i] <= valid[i-1] for i>0.
  - stage_start <= new valid vector, giving a one-cycle pulse per occupied stage.
  - retired increments if valid[STAGES-1] was 1.
  - If issue: issued increments.
    - The first issue of a frame keeps addr_vertex and addr_color at the bases.
    - Each later issue adds VERTEX_STRIDE to addr_vertex and COLOR_STRIDE to addr_color, modulo 2^MADDR_WIDTH.
  - If the new valid vector is all zero: state <= IDLE, frame_end pulses and irq sets.
- Latency:
  - stage_start follows advance by exactly 1 cycle.
  - A frame of N triangles takes exactly N+STAGES advances.
- irq: set at frame end, cleared by irq_clear. If set and clear occur in the same cycle, set wins.
- abort has the highest priority.
  - Takes effect at the next edge: state <= IDLE, all valid and done_seen bits cleared.
  - No stage_start, no frame_end, no irq change, and no advance in that cycle.
  - issued and retired hold their values.
- Reset asserted mid-frame returns the block to the reset values immediately, because reset is asynchronous.

Test Plan:
- Normal frame:
  - Stimulus: count=4, bases 0x1000 and 0x2000, STAGES=3; each stage_done returned 2 cycles after its stage_start.
  - Required: addr_vertex takes 0x1000, 0x1012, 0x1024, 0x1036 and addr_color takes 0x2000, 0x2002, 0x2004, 0x2006.
  - Required: exactly 7 advances; retired=4; a single frame_end pulse; irq=1; busy falls with frame_end.
- Zero-triangle frame:
  - Stimulus: count=0 with frame_start.
  - Required: frame_end and irq one cycle later; busy stays 0; no stage_start.
- Skewed stage completion:
  - Stimulus: count=2, stage 1 done delayed 10 cycles.
  - Required: advance waits for it; stage 0 done earlier is held in done_seen and not lost; fill stages that are not valid never block.
- Abort:
  - Stimulus: abort at the cycle after the 3rd advance of a count=5 frame.
  - Required: next cycle stage_valid=0, busy=0, no frame_end, irq unchanged; a following frame_start runs cleanly from the new bases.
- Interrupt and frame_start while busy:
  - Stimulus: irq_clear coincident with frame end.
  - Required: irq stays 1; irq_clear on its own clears it; frame_start during RUN leaves the latched count and bases unchanged.
- Asynchronous reset:
  - Stimulus: reset_n pulsed low mid-edge while RUN with stage_start active.
  - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/tri_pipe_scheduler_if.sv
// Frame-control and stage-handshake bundle between the GPU top level and the
// triangle pipeline scheduler.
interface tri_pipe_scheduler_if #(
   parameter int unsigned MADDR_WIDTH = 32,
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned STAGES      = 3
);
   logic                   frame_start;
   logic                   abort;
   logic [COUNT_WIDTH-1:0] triangles_count;
   logic [MADDR_WIDTH-1:0] base_addr_vertex;
   logic [MADDR_WIDTH-1:0] base_addr_color;
   logic [STAGES-1:0]      stage_done;
   logic                   irq_clear;

   logic [STAGES-1:0]      stage_start;
   logic [STAGES-1:0]      stage_valid;
   logic                   advance;
   logic [MADDR_WIDTH-1:0] addr_vertex;
   logic [MADDR_WIDTH-1:0] addr_color;
   logic [COUNT_WIDTH-1:0] issued;
   logic [COUNT_WIDTH-1:0] retired;
   logic                   busy;
   logic                   frame_end;
   logic                   irq;

   modport master (
      output frame_start, abort, triangles_count, base_addr_vertex, base_addr_color,
             stage_done, irq_clear,
      input  stage_start, stage_valid, advance, addr_vertex, addr_color, issued, retired,
             busy, frame_end, irq
   );

   modport slave (
      input  frame_start, abort, triangles_count, base_addr_vertex, base_addr_color,
             stage_done, irq_clear,
      output stage_start, stage_valid, advance, addr_vertex, addr_color, issued, retired,
             busy, frame_end, irq
   );
endinterface

// File: rtl/tri_pipe_scheduler.sv
// Occupancy-tracking scheduler that moves a frame of triangles through STAGES
// compute stages and generates per-triangle vertex/color addresses.
module tri_pipe_scheduler #(
   parameter int unsigned MADDR_WIDTH   = 32,
   parameter int unsigned COUNT_WIDTH   = 32,
   parameter int unsigned STAGES        = 3,
   parameter int unsigned VERTEX_STRIDE = 18,
   parameter int unsigned COLOR_STRIDE  = 2
) (
   input logic                 clk,
   input logic                 reset_n,
   tri_pipe_scheduler_if.slave bus
);
   localparam logic [MADDR_WIDTH-1:0] VStride = MADDR_WIDTH'(VERTEX_STRIDE);
   localparam logic [MADDR_WIDTH-1:0] CStride = MADDR_WIDTH'(COLOR_STRIDE);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                 state_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] issued_q;
   logic [COUNT_WIDTH-1:0] retired_q;
   logic [MADDR_WIDTH-1:0] addr_vertex_q;
   logic [MADDR_WIDTH-1:0] addr_color_q;
   logic [STAGES-1:0]      valid_q;
   logic [STAGES-1:0]      done_seen_q;
   logic [STAGES-1:0]      stage_start_q;
   logic                   frame_end_q;
   logic                   irq_q;

   logic [STAGES-1:0]      ready;
   logic [STAGES-1:0]      valid_next;
   logic                   advance;
   logic                   issue;

   // An empty stage is always ready, so fill and drain never stall.
   always_comb begin
      ready         = ~valid_q | done_seen_q | bus.stage_done;
      advance       = (state_q == StRun) && !bus.abort && (&ready);
      issue         = issued_q < count_q;
      valid_next    = valid_q << 1;
      valid_next[0] = issue;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         count_q       <= '0;
         issued_q      <= '0;
         retired_q     <= '0;
         addr_vertex_q <= '0;
         addr_color_q  <= '0;
         valid_q       <= '0;
         done_seen_q   <= '0;
         stage_start_q <= '0;
         frame_end_q   <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         stage_start_q <= '0;
         frame_end_q   <= 1'b0;
         if (bus.irq_clear) begin
            irq_q <= 1'b0;
         end
         if (bus.abort) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            done_seen_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.frame_start) begin
                     count_q       <= bus.triangles_count;
                     issued_q      <= '0;
                     retired_q     <= '0;
                     addr_vertex_q <= bus.base_addr_vertex;
                     addr_color_q  <= bus.base_addr_color;
                     if (bus.triangles_count == '0) begin
                        frame_end_q <= 1'b1;
                        irq_q       <= 1'b1;
                     end else begin
                        state_q <= StRun;
                     end
                  end
               end
               StRun: begin
                  if (advance) begin
                     valid_q       <= valid_next;
                     stage_start_q <= valid_next;
                     done_seen_q   <= '0;
                     if (valid_q[STAGES-1]) begin
                        retired_q <= retired_q + COUNT_WIDTH'(1);
                     end
                     if (issue) begin
                        issued_q <= issued_q + COUNT_WIDTH'(1);
                        // The first triangle of a frame sits at the latched bases.
                        if (issued_q != '0) begin
                           addr_vertex_q <= addr_vertex_q + VStride;
                           addr_color_q  <= addr_color_q + CStride;
                        end
                     end
                     if (valid_next == '0) begin
                        state_q     <= StIdle;
                        frame_end_q <= 1'b1;
                        irq_q       <= 1'b1;
                     end
                  end else begin
                     done_seen_q <= done_seen_q | (bus.stage_done & valid_q);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.stage_start = stage_start_q;
   assign bus.stage_valid = valid_q;
   assign bus.advance     = advance;
   assign bus.addr_vertex = addr_vertex_q;
   assign bus.addr_color  = addr_color_q;
   assign bus.issued      = issued_q;
   assign bus.retired     = retired_q;
   assign bus.busy        = (state_q == StRun);
   assign bus.frame_end   = frame_end_q;
   assign bus.irq         = irq_q;
endmodule

// File: tb/tb_tri_pipe_scheduler.sv
// Directed bench for tri_pipe_scheduler: stage responders with per-stage latency and
// hand-computed expectations for addresses, advance counts and frame control.
module tb_tri_pipe_scheduler;
   localparam int unsigned STAGES = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tri_pipe_scheduler_if #(.MADDR_WIDTH(32), .COUNT_WIDTH(32), .STAGES(STAGES)) bus ();

   tri_pipe_scheduler #(
      .MADDR_WIDTH  (32),
      .COUNT_WIDTH  (32),
      .STAGES       (STAGES),
      .VERTEX_STRIDE(18),
      .COLOR_STRIDE (2)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Stage responders: done pulses dly[i] cycles after stage_start[i].
   int unsigned dly  [STAGES];
   int unsigned rcnt [STAGES] = '{default: 0};
   always @(negedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
         bus.stage_done[i] = 1'b0;
         if (!reset_n || !bus.stage_valid[i]) begin
            rcnt[i] = 0;
         end else if (rcnt[i] != 0) begin
            rcnt[i] = rcnt[i] - 1;
            if (rcnt[i] == 0) bus.stage_done[i] = 1'b1;
         end
         if (reset_n && bus.stage_start[i]) rcnt[i] = dly[i];
      end
   end

   // Monitor samples one time unit before each rising edge.
   int          cyc = 0, adv_cnt = 0, s0_cnt = 0, ss_cnt = 0, fe_cnt = 0;
   int          adv_cyc [64];
   logic [31:0] av [64];
   logic [31:0] ac [64];
   logic        fe_busy = 1'b0, fe_prev_busy = 1'b0, fe_irq = 1'b0, prev_busy = 1'b0;
   always @(negedge clk) begin
      #4;
      cyc++;
      if (bus.advance) begin
         adv_cyc[adv_cnt % 64] = cyc;
         adv_cnt++;
      end
      if (bus.stage_start[0]) begin
         av[s0_cnt % 64] = bus.addr_vertex;
         ac[s0_cnt % 64] = bus.addr_color;
         s0_cnt++;
      end
      if (bus.stage_start != '0) ss_cnt++;
      if (bus.frame_end) begin
         fe_cnt++;
         fe_busy      = bus.busy;
         fe_prev_busy = prev_busy;
         fe_irq       = bus.irq;
      end
      prev_busy = bus.busy;
   end

   task automatic start_frame(input logic [31:0] n, input logic [31:0] va, input logic [31:0] ca);
      @(negedge clk);
      bus.triangles_count  = n;
      bus.base_addr_vertex = va;
      bus.base_addr_color  = ca;
      bus.frame_start      = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   task automatic wait_frame_end(input int target, input string tag);
      int n = 0;
      while (fe_cnt < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(fe_cnt >= target), 32'd1);
   endtask

   task automatic check_zero(input string pfx);
      check_eq({pfx, "_stage_start"}, 32'(bus.stage_start), 32'd0);
      check_eq({pfx, "_stage_valid"}, 32'(bus.stage_valid), 32'd0);
      check_eq({pfx, "_advance"}, 32'(bus.advance), 32'd0);
      check_eq({pfx, "_addr_vertex"}, bus.addr_vertex, 32'd0);
      check_eq({pfx, "_addr_color"}, bus.addr_color, 32'd0);
      check_eq({pfx, "_issued"}, bus.issued, 32'd0);
      check_eq({pfx, "_retired"}, bus.retired, 32'd0);
      check_eq({pfx, "_busy"}, 32'(bus.busy), 32'd0);
      check_eq({pfx, "_frame_end"}, 32'(bus.frame_end), 32'd0);
      check_eq({pfx, "_irq"}, 32'(bus.irq), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a0, a1, s0, f0, ss0, n;
      logic [31:0] exp_v [4];
      logic [31:0] exp_c [4];
      exp_v = '{32'h1000, 32'h1012, 32'h1024, 32'h1036};
      exp_c = '{32'h2000, 32'h2002, 32'h2004, 32'h2006};
      bus.frame_start      = 1'b0;
      bus.abort            = 1'b0;
      bus.irq_clear        = 1'b0;
      bus.triangles_count  = '0;
      bus.base_addr_vertex = '0;
      bus.base_addr_color  = '0;
      for (int i = 0; i < STAGES; i++) dly[i] = 2;

      // Reset state
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;

      // Normal frame: 4 triangles, 3 stages, 2-cycle stages
      a0 = adv_cnt; s0 = s0_cnt; f0 = fe_cnt;
      start_frame(32'd4, 32'h1000, 32'h2000);
      check_eq("norm_busy_run", 32'(bus.busy), 32'd1);
      check_eq("norm_issued_start", bus.issued, 32'd0);
      wait_frame_end(f0 + 1, "norm_frame_end_seen");
      check_eq("norm_advances", 32'(adv_cnt - a0), 32'd7);
      check_eq("norm_retired", bus.retired, 32'd4);
      check_eq("norm_issued", bus.issued, 32'd4);
      check_eq("norm_irq", 32'(bus.irq), 32'd1);
      check_eq("norm_busy_at_fe", 32'(fe_busy), 32'd0);
      check_eq("norm_busy_before_fe", 32'(fe_prev_busy), 32'd1);
      check_eq("norm_s0_starts", 32'(s0_cnt - s0), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("norm_addr_vertex%0d", k), av[(s0 + k) % 64], exp_v[k]);
         check_eq($sformatf("norm_addr_color%0d", k), ac[(s0 + k) % 64], exp_c[k]);
      end
      for (int k = 0; k < 6; k++) begin
         check_eq($sformatf("norm_adv_gap%0d", k),
                  32'(adv_cyc[(a0 + k + 1) % 64] - adv_cyc[(a0 + k) % 64]), 32'd3);
      end
      repeat (5) @(negedge clk);
      check_eq("norm_single_fe", 32'(fe_cnt - f0), 32'd1);

      // Zero-triangle frame
      bus.irq_clear = 1'b1;
      @(negedge clk);
      bus.irq_clear = 1'b0;
      @(negedge clk);
      check_eq("zero_irq_cleared", 32'(bus.irq), 32'd0);
      ss0 = ss_cnt; f0 = fe_cnt;
      bus.triangles_count  = 32'd0;
      bus.base_addr_vertex = 32'h7000;
      bus.base_addr_color  = 32'h7800;
      bus.frame_start      = 1'b1;
      @(posedge clk);
      #1;
      check_eq("zero_frame_end", 32'(bus.frame_end), 32'd1);
      check_eq("zero_irq", 32'(bus.irq), 32'd1);
      check_eq("zero_busy", 32'(bus.busy), 32'd0);
      check_eq("zero_addr_vertex", bus.addr_vertex, 32'h7000);
      @(negedge clk);
      bus.frame_start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("zero_frame_end_pulse", 32'(bus.frame_end), 32'd0);
      check_eq("zero_busy_after", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("zero_no_stage_start", 32'(ss_cnt - ss0), 32'd0);
      check_eq("zero_single_fe", 32'(fe_cnt - f0), 32'd1);

      // Skewed completion: stage 1 takes 10 cycles longer
      dly[1] = 12;
      a0 = adv_cnt; f0 = fe_cnt;
      start_frame(32'd2, 32'h100, 32'h200);
      wait_frame_end(f0 + 1, "skew_frame_end_seen");
      check_eq("skew_advances", 32'(adv_cnt - a0), 32'd5);
      check_eq("skew_retired", bus.retired, 32'd2);
      check_eq("skew_gap0", 32'(adv_cyc[(a0 + 1) % 64] - adv_cyc[a0 % 64]), 32'd3);
      check_eq("skew_gap1", 32'(adv_cyc[(a0 + 2) % 64] - adv_cyc[(a0 + 1) % 64]), 32'd13);
      check_eq("skew_gap2", 32'(adv_cyc[(a0 + 3) % 64] - adv_cyc[(a0 + 2) % 64]), 32'd13);
      check_eq("skew_gap3", 32'(adv_cyc[(a0 + 4) % 64] - adv_cyc[(a0 + 3) % 64]), 32'd3);
      dly[1] = 2;

      // Abort after the 3rd advance of a 5-triangle frame (irq is 1 here)
      a0 = adv_cnt; f0 = fe_cnt;
      start_frame(32'd5, 32'h1000, 32'h2000);
      n = 0;
      while (adv_cnt - a0 < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("abort_third_adv_seen", 32'(adv_cnt - a0 >= 3), 32'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_eq("abort_valid", 32'(bus.stage_valid), 32'd0);
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_irq", 32'(bus.irq), 32'd1);
      check_eq("abort_issued", bus.issued, 32'd3);
      check_eq("abort_retired", bus.retired, 32'd0);
      ss0 = ss_cnt;
      repeat (4) @(negedge clk);
      check_eq("abort_no_fe", 32'(fe_cnt - f0), 32'd0);
      check_eq("abort_no_adv", 32'(adv_cnt - a0), 32'd3);
      check_eq("abort_no_start", 32'(ss_cnt - ss0), 32'd0);
      a1 = adv_cnt;
      start_frame(32'd1, 32'h3000, 32'h4000);
      wait_frame_end(f0 + 1, "abort_rerun_fe_seen");
      check_eq("abort_rerun_adv", 32'(adv_cnt - a1), 32'd4);
      check_eq("abort_rerun_retired", bus.retired, 32'd1);
      check_eq("abort_rerun_addr_vertex", bus.addr_vertex, 32'h3000);
      check_eq("abort_rerun_addr_color", bus.addr_color, 32'h4000);

      // irq_clear held across frame end, plus frame_start while running
      bus.irq_clear = 1'b1;
      @(negedge clk);
      bus.irq_clear = 1'b0;
      @(negedge clk);
      check_eq("irq_cleared_pre", 32'(bus.irq), 32'd0);
      a0 = adv_cnt; f0 = fe_cnt;
      start_frame(32'd1, 32'h5000, 32'h6000);
      @(negedge clk);
      check_eq("irq_busy_mid", 32'(bus.busy), 32'd1);
      bus.triangles_count  = 32'd9;
      bus.base_addr_vertex = 32'hdead0000;
      bus.base_addr_color  = 32'hbeef0000;
      bus.frame_start      = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      bus.irq_clear   = 1'b1;
      wait_frame_end(f0 + 1, "irq_frame_end_seen");
      check_eq("irq_set_wins", 32'(fe_irq), 32'd1);
      check_eq("irq_clear_alone", 32'(bus.irq), 32'd0);
      bus.irq_clear = 1'b0;
      check_eq("busy_start_adv", 32'(adv_cnt - a0), 32'd4);
      check_eq("busy_start_issued", bus.issued, 32'd1);
      check_eq("busy_start_addr_vertex", bus.addr_vertex, 32'h5000);
      check_eq("busy_start_addr_color", bus.addr_color, 32'h6000);
      repeat (3) @(negedge clk);
      check_eq("busy_start_idle", 32'(bus.busy), 32'd0);

      // Asynchronous reset while a stage_start pulse is active
      start_frame(32'd3, 32'h1000, 32'h2000);
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         if (bus.stage_start != '0) break;
         n++;
      end
      check_eq("areset_start_seen", 32'(bus.stage_start != '0), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("areset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("areset_release_busy", 32'(bus.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
